// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage in-order pipeline: per-register advance/hold/bubble,
// memory wait-state watchdog, and stall/flush event counters.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | no memory stall in progress, to_cnt idle at 0
// MEM_WAIT | MEM stage stalled on memory, to_cnt counts stalled cycles
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_idx_i,
   input  logic [4:0]       id_rs2_idx_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic [4:0]       ex_rd_idx_i,
   input  logic             ex_is_load_i,
   input  logic             ex_busy_i,
   input  logic             ex_redirect_i,
   input  logic             mem_req_i,
   input  logic             mem_done_i,
   input  logic             trap_valid_i,
   output logic             pc_wen_o,
   output logic [1:0]       pc_sel_o,
   output logic             if_id_wen_o,
   output logic             id_ex_wen_o,
   output logic             ex_mem_wen_o,
   output logic             mem_wb_wen_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_flush_o,
   output logic             mem_wb_flush_o,
   output logic             mem_abort_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] PC_SEQ  = 2'b00;
   localparam logic [1:0] PC_BR   = 2'b01;
   localparam logic [1:0] PC_TRAP = 2'b10;

   state_t            state;
   state_t            state_nxt;
   logic [TO_W-1:0]   to_cnt;
   logic [TO_W-1:0]   to_cnt_nxt;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   logic rs1_hit;
   logic rs2_hit;
   logic load_use;
   logic timeout_hit;
   logic mem_stall;
   logic flush_evt;

   always_comb begin
      rs1_hit     = id_rs1_used_i && (id_rs1_idx_i == ex_rd_idx_i);
      rs2_hit     = id_rs2_used_i && (id_rs2_idx_i == ex_rd_idx_i);
      // x0 is never written, so a load targeting it cannot create a hazard
      load_use    = ex_is_load_i && (ex_rd_idx_i != 5'd0) && (rs1_hit || rs2_hit);
      timeout_hit = (state == MEM_WAIT) && (to_cnt == TO_W'(MEM_TIMEOUT)) && !mem_done_i;
      mem_stall   = mem_req_i && !mem_done_i;
   end

   always_comb begin
      pc_wen_o       = 1'b1;
      pc_sel_o       = PC_SEQ;
      if_id_wen_o    = 1'b1;
      id_ex_wen_o    = 1'b1;
      ex_mem_wen_o   = 1'b1;
      mem_wb_wen_o   = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      mem_wb_flush_o = 1'b0;
      mem_abort_o    = 1'b0;
      mem_timeout_o  = 1'b0;
      flush_evt      = 1'b0;
      state_nxt      = RUN;
      to_cnt_nxt     = '0;

      if (rst) begin
         pc_wen_o       = 1'b0;
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
         mem_wb_flush_o = 1'b1;
      end else if (trap_valid_i || timeout_hit) begin
         pc_sel_o       = PC_TRAP;
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
         // a trap carries its cause to WB; a timed-out op has nothing to retire
         mem_wb_flush_o = !trap_valid_i;
         mem_abort_o    = 1'b1;
         mem_timeout_o  = !trap_valid_i;
         flush_evt      = 1'b1;
      end else if (mem_stall) begin
         pc_wen_o       = 1'b0;
         if_id_wen_o    = 1'b0;
         id_ex_wen_o    = 1'b0;
         ex_mem_wen_o   = 1'b0;
         mem_wb_flush_o = 1'b1;
         state_nxt      = MEM_WAIT;
         to_cnt_nxt     = (state == RUN) ? TO_W'(1) : to_cnt + TO_W'(1);
      end else if (ex_busy_i) begin
         pc_wen_o       = 1'b0;
         if_id_wen_o    = 1'b0;
         id_ex_wen_o    = 1'b0;
         ex_mem_flush_o = 1'b1;
      end else if (ex_redirect_i) begin
         pc_sel_o       = PC_BR;
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         flush_evt      = 1'b1;
      end else if (load_use) begin
         pc_wen_o       = 1'b0;
         if_id_wen_o    = 1'b0;
         id_ex_flush_o  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         to_cnt    <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state  <= state_nxt;
         to_cnt <= to_cnt_nxt;
         if (!pc_wen_o)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_evt)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt;
   assign flush_cnt_o = flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage in-order pipeline (PC, if_id, id_ex, ex_mem, mem_wb).
- Each cycle it decides, per pipeline register, one of three actions: advance, hold, or load a bubble.
- It resolves load-use hazards, multi-cycle EX ops, branch redirects, data-memory wait states (with a timeout watchdog) and MEM-stage traps.
- It also keeps stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 255, number of MEM_WAIT cycles tolerated before abort (>=1)
TO_W, 8, width of the timeout counter (must hold MEM_TIMEOUT)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1_idx_i  in  5  decode-stage rs1 index
id_rs2_idx_i  in  5  decode-stage rs2 index
id_rs1_used_i  in  1  decode instruction reads rs1
id_rs2_used_i  in  1  decode instruction reads rs2
ex_rd_idx_i  in  5  EX-stage destination index
ex_is_load_i  in  1  EX-stage instruction is a load
ex_busy_i  in  1  EX multi-cycle unit not finished
ex_redirect_i  in  1  EX resolved a taken branch/jump
mem_req_i  in  1  MEM stage has an outstanding load/store
mem_done_i  in  1  memory response this cycle
trap_valid_i  in  1  MEM-stage instruction raises a trap
pc_wen_o  out  1  PC register update enable
pc_sel_o  out  2  00 sequential, 01 branch target, 10 trap vector
if_id_wen_o, id_ex_wen_o, ex_mem_wen_o, mem_wb_wen_o  out  1 each  register advance enable (0 = hold)
if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  load bubble (reset value); when asserted, wen is also 1
mem_abort_o  out  1  cancel the outstanding memory op
mem_timeout_o  out  1  one-cycle pulse on watchdog expiry
stall_cnt_o  out  CNT_W  cycles with pc_wen_o=0
flush_cnt_o  out  CNT_W  trap/timeout/redirect events

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high on rst.
- Output timing: all control outputs are combinational from the current inputs and registered state; there is zero-cycle latency.
- Registered state:
  - FSM {RUN, MEM_WAIT}
  - to_cnt[TO_W]
  - stall_cnt, flush_cnt
- Reset values: state=RUN, to_cnt=0, stall_cnt=0, flush_cnt=0.
- Outputs while rst=1: pc_wen=0, all four flushes=1, all wen=1, pc_sel=00, mem_abort=0, mem_timeout=0.
- Decision rules, strict priority, first match wins each cycle:
  - P1 trap: trap_valid_i=1, or timeout (state=MEM_WAIT, to_cnt==MEM_TIMEOUT, mem_done_i=0).
    - pc_wen=1, pc_sel=10.
    - Flush if_id, id_ex, ex_mem.
    - mem_wb advances for a trap (carries the trap bus to WB) and is flushed for a timeout.
    - mem_abort=1; mem_timeout=1 only in the timeout case.
    - flush_cnt+1; next state RUN; to_cnt<=0.
  - P2 memory stall: mem_req_i=1, mem_done_i=0.
    - pc, if_id, id_ex, ex_mem hold; mem_wb flushed.
    - Next state MEM_WAIT; to_cnt<=to_cnt+1.
    - Entering from RUN sets to_cnt=1, so the timeout fires after exactly MEM_TIMEOUT stalled cycles.
  - P3 EX busy: ex_busy_i=1.
    - pc, if_id, id_ex hold; ex_mem flushed; mem_wb advances.
  - P4 redirect: ex_redirect_i=1.
    - pc_wen=1, pc_sel=01; flush if_id and id_ex; others advance.
    - flush_cnt+1.
  - P5 load-use: ex_is_load_i=1, ex_rd_idx_i!=0, and (rs1_used and rs1==rd, or rs2_used and rs2==rd).
    - pc and if_id hold; id_ex flushed; others advance.
  - P6 otherwise: everything advances, no flush, pc_sel=00.
- Leaving MEM_WAIT without a stall (mem_done_i=1, or mem_req_i dropped): next state RUN, to_cnt<=0, and the lower-priority rules apply in the same cycle.
- Counters:
  - stall_cnt+1 on every non-reset cycle with pc_wen_o=0.
  - Both counters wrap modulo 2^CNT_W.
- Deferred redirects: a redirect or load-use masked by a higher-priority stall is not latched. The held id_ex re-presents it on the next cycle.
- Reset mid-MEM_WAIT: state returns to RUN immediately; no timeout pulse is issued.

Test Plan:
- Load-use: EX lw x5 with ID rs2=x5 used -> one cycle of pc_wen=0, if_id_wen=0, id_ex_flush=1; stall_cnt 0->1; the next cycle advances. The same stimulus with rd=x0 -> no stall.
- Memory wait: mem_req_i=1 for 3 cycles, mem_done_i in the 4th -> 3 cycles of hold with mem_wb_flush=1, to_cnt 1,2,3; 4th cycle all advance, state RUN, stall_cnt=3.
- Timeout (MEM_TIMEOUT=4): mem_req_i held, mem_done_i never arrives -> 4 stall cycles; 5th cycle mem_timeout_o=1, mem_abort_o=1, pc_sel=10, all four flushes=1; flush_cnt=1, state RUN.
- Trap during MEM_WAIT: after 2 wait cycles trap_valid_i=1 -> same cycle pc_sel=10, mem_wb advances, mem_timeout_o=0, to_cnt=0.
- Priority: ex_redirect_i=1 with mem stall -> hold (P2), pc_sel=00; on mem_done_i the redirect fires, pc_sel=01 and flush if_id/id_ex. ex_busy_i with redirect -> P3 wins, ex_mem_flush=1.
- Reset/wrap: assert rst in MEM_WAIT -> next cycle state RUN with counters 0. With CNT_W=4, 17 stall cycles -> stall_cnt=1.
